// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch (read-only)
// and load/store ports; one access in flight, registered responses, range trap.
module mem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MEMDEPTH = 25
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  output logic [DW-1:0] f_rdata,
  output logic          f_err,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr,
  output logic [DW-1:0] mem_datain,
  input  logic [DW-1:0] mem_dataout,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(MEMDEPTH);

  state_e          state_q, state_d;
  logic            sel_q;        // 1 = data port owns the transaction
  logic            last_q;       // 1 = data port was granted last
  logic [AW-1:0]   addr_q;
  logic            wr_q;
  logic [DW-1:0]   wdata_q;
  logic            err_q;
  logic [DW-1:0]   f_rdata_q, d_rdata_q;
  logic            f_err_q, d_err_q;

  logic            grant_s;
  logic            pick_d_s;
  logic [AW-1:0]   req_addr_s;
  logic            req_err_s;
  logic [DW-1:0]   rd_s;

  // Next-state and arbitration decision
  always_comb begin
    state_d  = state_q;
    grant_s  = 1'b0;
    pick_d_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (f_req || d_req) begin
          grant_s = 1'b1;
          state_d = S_ACCESS;
          if (f_req && d_req) begin
            pick_d_s = ~last_q;
          end else begin
            pick_d_s = d_req;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign req_addr_s = pick_d_s ? d_addr : f_addr;
  assign req_err_s  = ({1'b0, req_addr_s} >= DEPTH_C);
  // Out-of-range accesses and stores both return zero read data
  assign rd_s       = (err_q || wr_q) ? {DW{1'b0}} : mem_dataout;

  // State, request latches and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      sel_q     <= 1'b0;
      last_q    <= 1'b1;
      addr_q    <= {AW{1'b0}};
      wr_q      <= 1'b0;
      wdata_q   <= {DW{1'b0}};
      err_q     <= 1'b0;
      f_rdata_q <= {DW{1'b0}};
      d_rdata_q <= {DW{1'b0}};
      f_err_q   <= 1'b0;
      d_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_s) begin
        sel_q   <= pick_d_s;
        last_q  <= pick_d_s;
        addr_q  <= req_addr_s;
        wr_q    <= pick_d_s & d_wr;
        wdata_q <= pick_d_s ? d_wdata : {DW{1'b0}};
        err_q   <= req_err_s;
      end
      if (state_q == S_ACCESS) begin
        if (sel_q) begin
          d_rdata_q <= rd_s;
          d_err_q   <= err_q;
        end else begin
          f_rdata_q <= rd_s;
          f_err_q   <= err_q;
        end
      end
    end
  end

  assign mem_addr   = (state_q == S_ACCESS) ? addr_q  : {AW{1'b0}};
  assign mem_datain = (state_q == S_ACCESS) ? wdata_q : {DW{1'b0}};
  assign mem_wr     = (state_q == S_ACCESS) & wr_q & ~err_q;
  assign f_ack      = (state_q == S_DONE) & ~sel_q;
  assign d_ack      = (state_q == S_DONE) & sel_q;
  assign f_rdata    = f_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign f_err      = f_err_q;
  assign d_err      = d_err_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int DEPTH = 25;

  logic          clk = 1'b0;
  logic          rst;
  logic          f_req, d_req, d_wr;
  logic [AW-1:0] f_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          f_ack, f_err, d_ack, d_err, mem_wr, busy;
  logic [DW-1:0] f_rdata, d_rdata, mem_datain, mem_dataout;
  logic [AW-1:0] mem_addr;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] model_mem [0:(1<<AW)-1];

  mem_arbiter #(.AW(AW), .DW(DW), .MEMDEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_datain(mem_datain),
    .mem_dataout(mem_dataout), .busy(busy)
  );

  always #5 clk = ~clk;

  assign mem_dataout = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_datain;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model: a grant happens at the edge where the arbiter is
  // free and someone requests; ACCESS is the cycle after, ack the one after that.
  int            cyc, g;
  logic          have_txn, m_sel, m_last, m_wr, m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [DW-1:0] e_f_rdata, e_d_rdata;
  logic          e_f_err, e_d_err;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc <= 0; g <= 0; have_txn <= 1'b0; m_sel <= 1'b0; m_last <= 1'b1;
      m_wr <= 1'b0; m_err <= 1'b0; m_addr <= '0; m_wdata <= '0; m_rdata <= '0;
      e_f_rdata <= '0; e_d_rdata <= '0; e_f_err <= 1'b0; e_d_err <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (have_txn && cyc == g) begin
        if (m_sel) begin e_d_rdata <= m_rdata; e_d_err <= m_err; end
        else       begin e_f_rdata <= m_rdata; e_f_err <= m_err; end
      end
      if ((!have_txn || cyc >= g + 2) && (f_req || d_req)) begin
        automatic logic          pd = (f_req && d_req) ? !m_last : d_req;
        automatic logic [AW-1:0] a  = pd ? d_addr : f_addr;
        automatic logic          e  = (int'(a) >= DEPTH);
        automatic logic          w  = pd && d_wr;
        have_txn <= 1'b1;
        g        <= cyc + 1;
        m_sel    <= pd;
        m_last   <= pd;
        m_addr   <= a;
        m_err    <= e;
        m_wr     <= w;
        m_wdata  <= pd ? d_wdata : '0;
        m_rdata  <= (e || w) ? '0 : model_mem[a];
        if (w && !e) model_mem[a] <= d_wdata;
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    automatic int ph = have_txn ? (cyc - g) : 99;
    automatic logic acc = rst && (ph == 0);
    automatic logic dn  = rst && (ph == 1);
    chk("busy",       busy,       32'(acc || dn));
    chk("mem_wr",     mem_wr,     32'(acc && m_wr && !m_err));
    chk("mem_addr",   mem_addr,   acc ? 32'(m_addr) : 32'd0);
    chk("mem_datain", mem_datain, acc ? 32'(m_wdata) : 32'd0);
    chk("f_ack",      f_ack,      32'(dn && !m_sel));
    chk("d_ack",      d_ack,      32'(dn && m_sel));
    chk("f_rdata",    f_rdata,    32'(e_f_rdata));
    chk("d_rdata",    d_rdata,    32'(e_d_rdata));
    chk("f_err",      f_err,      32'(e_f_err));
    chk("d_err",      d_err,      32'(e_d_err));
  end

  task automatic do_fetch(input logic [AW-1:0] a, output int lat);
    lat = 0;
    f_req = 1'b1; f_addr = a;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (f_ack && lat == 0) lat = i;
      if (lat != 0) break;
    end
    if (lat == 0) chk("fetch_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_data(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         output int lat);
    lat = 0;
    d_req = 1'b1; d_wr = w; d_addr = a; d_wdata = wd;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (d_ack && lat == 0) lat = i;
      if (lat != 0) break;
    end
    if (lat == 0) chk("data_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat;
    int log_who[$];
    int log_at[$];
    int nack, nlow;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = 8'hA0 + 8'(i);
      model_mem[i] = 8'hA0 + 8'(i);
    end
    mem[3] = 8'h0A; model_mem[3] = 8'h0A;
    rst = 1'b0; f_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    f_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 32'd0);
    chk("rst_f_rdata", f_rdata, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Fetch only
    do_fetch(8'd3, lat);
    chk("t2_latency", lat, 32'd2);
    chk("t2_f_rdata", f_rdata, 32'h0A);
    chk("t2_f_err", f_err, 32'd0);
    f_req = 1'b0;
    @(negedge clk);

    // Store then load
    do_data(1'b1, 8'd7, 8'h55, lat);
    chk("t3_st_latency", lat, 32'd2);
    chk("t3_st_rdata", d_rdata, 32'd0);
    d_req = 1'b0;
    @(negedge clk);
    do_data(1'b0, 8'd7, 8'h00, lat);
    chk("t3_ld_rdata", d_rdata, 32'h55);
    d_req = 1'b0;
    @(negedge clk);

    // Out of range store
    do_data(1'b1, 8'd25, 8'h33, lat);
    chk("t5_d_err", d_err, 32'd1);
    chk("t5_d_rdata", d_rdata, 32'd0);
    d_req = 1'b0;
    @(negedge clk);
    chk("t5_mem25", mem[25], 32'hB9);
    chk("t3_mem7", mem[7], 32'h55);

    // Contention from reset
    rst = 1'b0;
    f_req = 1'b1; f_addr = 8'd4;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 8'd5; d_wdata = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    for (int j = 0; j < 11; j++) begin
      @(negedge clk);
      if (f_ack) begin log_who.push_back(0); log_at.push_back(j); end
      if (d_ack) begin log_who.push_back(1); log_at.push_back(j); end
    end
    f_req = 1'b0; d_req = 1'b0;
    chk("t4_nacks", log_who.size(), 32'd4);
    if (log_who.size() == 4) begin
      chk("t4_g0", log_who[0], 32'd0);
      chk("t4_g1", log_who[1], 32'd1);
      chk("t4_g2", log_who[2], 32'd0);
      chk("t4_g3", log_who[3], 32'd1);
      chk("t4_first_ack", log_at[0], 32'd1);
      for (int k = 0; k < 3; k++) chk("t4_spacing", log_at[k+1] - log_at[k], 32'd3);
    end
    chk("t4_f_rdata", f_rdata, 32'hA4);
    chk("t4_d_rdata", d_rdata, 32'hA5);
    repeat (2) @(negedge clk);

    // Held fetch request for 9 cycles
    nack = 0; nlow = 0;
    f_req = 1'b1; f_addr = 8'd2;
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      if (f_ack) nack++;
      if (!busy) nlow++;
    end
    f_req = 1'b0;
    chk("t6_acks", nack, 32'd3);
    chk("t6_busy_low", nlow, 32'd3);
    chk("t6_f_rdata", f_rdata, 32'hA2);
    repeat (2) @(negedge clk);

    // Reset in the middle of a store access
    d_req = 1'b1; d_wr = 1'b1; d_addr = 8'd9; d_wdata = 8'h77;
    @(posedge clk);
    #1;
    chk("t1_wr_before", mem_wr, 32'd1);
    rst = 1'b0;
    #1;
    chk("t1_mem_wr", mem_wr, 32'd0);
    chk("t1_busy", busy, 32'd0);
    chk("t1_d_ack", d_ack, 32'd0);
    chk("t1_f_rdata", f_rdata, 32'd0);
    chk("t1_d_rdata", d_rdata, 32'd0);
    d_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t1_mem9", mem[9], 32'hA9);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
